// File: rtl/m_axi_stream_pkg.sv
// Shared stream parameters and control-state encoding for the AXI-Stream master/slave pair.
package m_axi_stream_pkg;
  localparam int DWIDTH  = 32;
  localparam int BUFSIZE = 4;
  localparam int LENW    = BUFSIZE + 1;
  localparam int STRBW   = DWIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/m_axi_stream_axis_out_queue.sv
// Two-entry output queue feeding the AXI-Stream master; head word is presented combinationally.
module axis_out_queue
  import m_axi_stream_pkg::*;
#(
  parameter int WIDTH = DWIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop    = pop && (count != 2'd0);
    do_push   = push && ((count != 2'd2) || do_pop);
    head_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m_axi_stream.sv
// AXI4-Stream master: pops a burst of len words from a 1-cycle-latency buffer and streams them out.
//   state   | meaning
//   S_IDLE  | waiting for start with a non-zero length
//   S_READ  | issuing buffer reads until len reads have been issued
//   S_DRAIN | all reads issued; emptying the queue until the tlast handshake
module m_axi_stream
  import m_axi_stream_pkg::*;
(
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [LENW-1:0]   len,
  input  logic              buf_isempty,
  input  logic [DWIDTH-1:0] buf_rdata,
  output logic              buf_re,
  output logic              tvalid,
  output logic [DWIDTH-1:0] tdata,
  output logic [STRBW-1:0]  tstrb,
  output logic              tlast,
  input  logic              tready,
  output logic              busy,
  output logic              done
);

  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  state_t          state;
  state_t          state_nxt;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] issued;
  logic [LENW-1:0] sent;
  logic            rd_inflight;
  logic            done_q;
  logic [1:0]      q_count;
  logic [2:0]      pending;
  logic            hs;
  logic            start_ok;
  logic            last_rd;

  axis_out_queue #(.WIDTH(DWIDTH)) u_queue (
    .clk       (clk),
    .rst       (xrst),
    .push      (rd_inflight),
    .push_data (buf_rdata),
    .pop       (hs),
    .count     (q_count),
    .head_data (tdata)
  );

  // A pop in the same cycle frees a slot, which keeps one beat per cycle with tready high.
  always_comb begin
    tvalid   = (q_count != 2'd0);
    tstrb    = '1;
    hs       = tvalid && tready;
    tlast    = tvalid && (sent == (len_q - LEN_ONE));
    pending  = {1'b0, q_count} + {2'b00, rd_inflight};
    buf_re   = (state == S_READ) && (issued < len_q) && !buf_isempty &&
               (q_count != 2'd2) && (pending < (3'd2 + {2'b00, hs}));
    start_ok = (state == S_IDLE) && !done_q && start && (len != '0);
    last_rd  = buf_re && (issued == (len_q - LEN_ONE));
    busy     = (state != S_IDLE) || done_q;
    done     = done_q;

    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok)     state_nxt = S_READ;
      S_READ:  if (last_rd)      state_nxt = S_DRAIN;
      S_DRAIN: if (hs && tlast)  state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      issued      <= '0;
      sent        <= '0;
      rd_inflight <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= buf_re;
      done_q      <= (state == S_DRAIN) && hs && tlast;
      if (start_ok) begin
        len_q  <= len;
        issued <= '0;
        sent   <= '0;
      end else begin
        if (buf_re) issued <= issued + LEN_ONE;
        if (hs)     sent   <= sent + LEN_ONE;
      end
    end
  end

endmodule
